// File: rtl/fc_argmax_classifier.sv
// Captures the FC layer's sign-magnitude output vector on a done_flag rising edge,
// scans it serially for the largest logit and presents index/value on valid/ready.
module fc_argmax_classifier #(
   parameter int DATA_WIDTH = 16,
   parameter int NODES      = 10,
   parameter int IDX_W      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        done_flag,
   input  logic [DATA_WIDTH*NODES-1:0] fc_in,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [IDX_W-1:0]            class_idx,
   output logic [DATA_WIDTH-1:0]       max_val,
   output logic                        busy,
   output logic                        drop_flag
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam int MAG_W = DATA_WIDTH - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);

   logic [1:0]                  state_q, state_d;
   logic                        done_q, done_d;
   logic [DATA_WIDTH*NODES-1:0] snap_q, snap_d;
   logic [IDX_W-1:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]            best_idx_q, best_idx_d;
   logic [DATA_WIDTH-1:0]       best_val_q, best_val_d;
   logic                        out_valid_q, out_valid_d;
   logic [IDX_W-1:0]            class_idx_q, class_idx_d;
   logic [DATA_WIDTH-1:0]       max_val_q, max_val_d;
   logic                        drop_q, drop_d;

   logic                        start;
   logic [DATA_WIDTH-1:0]       cand;
   logic [IDX_W-1:0]            next_idx;
   logic [DATA_WIDTH-1:0]       next_val;

   // Strict sign-magnitude greater-than; a zero magnitude counts as positive so -0 == +0.
   function automatic logic sm_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      logic [MAG_W-1:0] am, bm;
      logic             a_neg, b_neg;
      am    = a[MAG_W-1:0];
      bm    = b[MAG_W-1:0];
      a_neg = a[DATA_WIDTH-1] & (am != '0);
      b_neg = b[DATA_WIDTH-1] & (bm != '0);
      if (a_neg != b_neg) sm_gt = b_neg;
      else if (!a_neg)    sm_gt = (am > bm);
      else                sm_gt = (am < bm);
   endfunction

   always_comb begin
      state_d     = state_q;
      done_d      = done_flag;
      snap_d      = snap_q;
      cnt_d       = cnt_q;
      best_idx_d  = best_idx_q;
      best_val_d  = best_val_q;
      out_valid_d = out_valid_q;
      class_idx_d = class_idx_q;
      max_val_d   = max_val_q;
      drop_d      = drop_q;

      start    = done_flag & ~done_q;
      cand     = snap_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
      next_idx = best_idx_q;
      next_val = best_val_q;
      if (sm_gt(cand, best_val_q)) begin
         next_idx = cnt_q;
         next_val = cand;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d     = fc_in;
               best_idx_d = '0;
               best_val_d = fc_in[DATA_WIDTH-1:0];
               cnt_d      = IDX_W'(1);
               state_d    = S_SCAN;
            end
         end
         S_SCAN: begin
            if (start) drop_d = 1'b1;
            best_idx_d = next_idx;
            best_val_d = next_val;
            if (cnt_q == LAST_IDX) begin
               class_idx_d = next_idx;
               max_val_d   = next_val;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         S_HOLD: begin
            if (start) drop_d = 1'b1;
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         done_q      <= 1'b0;
         snap_q      <= '0;
         cnt_q       <= '0;
         best_idx_q  <= '0;
         best_val_q  <= '0;
         out_valid_q <= 1'b0;
         class_idx_q <= '0;
         max_val_q   <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         snap_q      <= snap_d;
         cnt_q       <= cnt_d;
         best_idx_q  <= best_idx_d;
         best_val_q  <= best_val_d;
         out_valid_q <= out_valid_d;
         class_idx_q <= class_idx_d;
         max_val_q   <= max_val_d;
         drop_q      <= drop_d;
      end
   end

   assign out_valid = out_valid_q;
   assign class_idx = class_idx_q;
   assign max_val   = max_val_q;
   assign busy      = (state_q != S_IDLE);
   assign drop_flag = drop_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level argmax model with a fixed-latency/handshake timeline.
module tb_fc_argmax_classifier;

   localparam int DW = 16;
   localparam int N  = 10;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            done_flag;
   logic [DW*N-1:0] fc_in;
   logic            out_ready;
   logic            out_valid;
   logic [IW-1:0]   class_idx;
   logic [DW-1:0]   max_val;
   logic            busy;
   logic            drop_flag;

   int checks = 0;
   int errors = 0;

   fc_argmax_classifier #(.DATA_WIDTH(DW), .NODES(N), .IDX_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .done_flag (done_flag),
      .fc_in     (fc_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .class_idx (class_idx),
      .max_val   (max_val),
      .busy      (busy),
      .drop_flag (drop_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   // Value of a sign-magnitude word as a plain signed integer.
   function automatic int score(input logic [DW-1:0] v);
      int mag;
      mag = int'(v[DW-2:0]);
      return v[DW-1] ? -mag : mag;
   endfunction

   function automatic void ref_argmax(input logic [DW*N-1:0] v, output logic [IW-1:0] idx,
                                      output logic [DW-1:0] val);
      idx = '0;
      val = v[DW-1:0];
      for (int k = 1; k < N; k++) begin
         if (score(v[k*DW +: DW]) > score(val)) begin
            idx = IW'(k);
            val = v[k*DW +: DW];
         end
      end
   endfunction

   // Behavioural model: result known at capture, revealed N-1 cycles later.
   bit            m_prev  = 1'b0;
   bit            m_valid = 1'b0;
   bit            m_drop  = 1'b0;
   int            m_phase = 0;
   int            m_left  = 0;
   logic [IW-1:0] m_idx   = '0;
   logic [DW-1:0] m_val   = '0;
   logic [IW-1:0] p_idx;
   logic [DW-1:0] p_val;

   always @(posedge clk) begin
      bit st;
      if (!reset) begin
         m_prev = 0; m_valid = 0; m_drop = 0; m_phase = 0; m_left = 0;
         m_idx = '0; m_val = '0;
      end else begin
         st = done_flag && !m_prev;
         m_prev = done_flag;
         if (m_phase == 0) begin
            if (st) begin
               ref_argmax(fc_in, p_idx, p_val);
               m_left  = N - 1;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (st) m_drop = 1;
            m_left--;
            if (m_left == 0) begin
               m_valid = 1; m_idx = p_idx; m_val = p_val; m_phase = 2;
            end
         end else begin
            if (st) m_drop = 1;
            if (out_ready) begin
               m_valid = 0; m_phase = 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("drop_flag", 32'(drop_flag), 32'(m_drop));
      chk("class_idx", 32'(class_idx), 32'(m_idx));
      chk("max_val", 32'(max_val), 32'(m_val));
   end

   task automatic set_elem(input int k, input logic [DW-1:0] v);
      fc_in[k*DW +: DW] = v;
   endtask

   task automatic rand_vec();
      for (int k = 0; k < N; k++) begin
         if ($urandom_range(0, 3) == 0) set_elem(k, DW'($urandom));
         else set_elem(k, {1'($urandom_range(0, 1)), 15'($urandom_range(0, 3))});
      end
   endtask

   task automatic wait_valid(input string name, output int lat);
      bit found;
      found = 0;
      lat = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) found = 1;
      end
      if (!found) chk({name, "_timeout"}, 32'(0), 32'(1));
   endtask

   // Drive a one-cycle done_flag pulse and wait for the result.
   task automatic capture(input string name, output int lat);
      done_flag = 1'b1;
      @(negedge clk);
      done_flag = 1'b0;
      wait_valid(name, lat);
      lat = lat + 1;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   int            lat;
   int            rises;
   bit            prev_v;
   logic [IW-1:0] e_idx;
   logic [DW-1:0] e_val;

   initial begin
      reset = 1'b0; done_flag = 1'b0; out_ready = 1'b0; fc_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_idx", 32'(class_idx), 32'(0));
      chk("rst_val", 32'(max_val), 32'(0));
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Positive maximum, capture-to-valid latency.
      fc_in = '0;
      set_elem(0, 16'h0010); set_elem(1, 16'h0050); set_elem(2, 16'h0020);
      capture("t1", lat);
      chk("t1_latency", 32'(lat - 1), 32'(9));
      chk("t1_idx", 32'(class_idx), 32'(1));
      chk("t1_val", 32'(max_val), 32'h0050);
      accept();
      chk("t1_valid_drop", 32'(out_valid), 32'(0));

      // All negative: smallest magnitude wins.
      for (int k = 0; k < N; k++) set_elem(k, 16'h8000 | 16'(k + 3));
      set_elem(7, 16'h8001);
      capture("t2", lat);
      chk("t2_idx", 32'(class_idx), 32'(7));
      chk("t2_val", 32'(max_val), 32'h8001);
      accept();

      // -0 ties +0; lowest index wins.
      for (int k = 0; k < N; k++) set_elem(k, 16'h8000 | 16'(k + 1));
      set_elem(2, 16'h8000); set_elem(5, 16'h0000);
      capture("t3", lat);
      chk("t3_idx", 32'(class_idx), 32'(2));
      chk("t3_val", 32'(max_val), 32'h8000);
      accept();

      // Long hold, then a start in the first IDLE cycle after handshake.
      rand_vec();
      capture("t4", lat);
      repeat (20) @(negedge clk);
      chk("t4_busy", 32'(busy), 32'(1));
      chk("t4_valid", 32'(out_valid), 32'(1));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("t4_valid_drop", 32'(out_valid), 32'(0));
      rand_vec();
      capture("t4b", lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      done_flag = 1'b1;
      @(negedge clk);
      done_flag = 1'b0;
      chk("t4_first_idle_busy", 32'(busy), 32'(1));
      chk("t4_no_drop", 32'(drop_flag), 32'(0));
      wait_valid("t4c", lat);
      accept();

      // Second edge during SCAN is dropped; first result stands.
      rand_vec();
      ref_argmax(fc_in, e_idx, e_val);
      done_flag = 1'b1;
      @(negedge clk);
      done_flag = 1'b0;
      repeat (2) @(negedge clk);
      rand_vec();
      done_flag = 1'b1;
      @(negedge clk);
      done_flag = 1'b0;
      chk("t5_drop", 32'(drop_flag), 32'(1));
      wait_valid("t5", lat);
      chk("t5_idx", 32'(class_idx), 32'(e_idx));
      chk("t5_val", 32'(max_val), 32'(e_val));
      accept();

      // Level held high yields exactly one result.
      rand_vec();
      out_ready = 1'b1;
      done_flag = 1'b1;
      rises = 0;
      prev_v = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (out_valid && !prev_v) rises++;
         prev_v = out_valid;
      end
      done_flag = 1'b0;
      out_ready = 1'b0;
      chk("t5_one_result", 32'(rises), 32'(1));
      @(negedge clk);

      // Start coincident with the HOLD handshake is dropped.
      rand_vec();
      capture("t5c", lat);
      out_ready = 1'b1;
      done_flag = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      done_flag = 1'b0;
      @(negedge clk);
      chk("t5_hs_drop_idle", 32'(busy), 32'(0));

      // Reset in the middle of SCAN aborts, then a fresh capture works.
      rand_vec();
      done_flag = 1'b1;
      @(negedge clk);
      done_flag = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t6_valid", 32'(out_valid), 32'(0));
      chk("t6_busy", 32'(busy), 32'(0));
      chk("t6_drop", 32'(drop_flag), 32'(0));
      chk("t6_idx", 32'(class_idx), 32'(0));
      chk("t6_val", 32'(max_val), 32'(0));
      reset = 1'b1;
      rand_vec();
      ref_argmax(fc_in, e_idx, e_val);
      capture("t6", lat);
      chk("t6_res_idx", 32'(class_idx), 32'(e_idx));
      chk("t6_res_val", 32'(max_val), 32'(e_val));
      accept();

      // Randomized traffic; the model checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rand_vec();
         if ($urandom_range(0, 5) == 0) done_flag = ~done_flag;
         out_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 499) != 0);
      end
      reset = 1'b1;
      done_flag = 1'b0;
      out_ready = 1'b1;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
